// File: rtl/multicycle_main_control_pkg.sv
// Shared definitions for the multi-cycle RV32 main control FSM: opcodes, ALU-control
// operation codes, mux select codes, branch fun3 codes and the FSM state type.
package multicycle_main_control_pkg;

  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [1:0] AluopAdd = 2'b00;
  localparam logic [1:0] AluopBr  = 2'b01;
  localparam logic [1:0] AluopR   = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcARs1   = 2'b01;
  localparam logic [1:0] SrcAOldPc = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBFour = 2'b01;
  localparam logic [1:0] SrcBImm  = 2'b10;

  localparam logic [1:0] MemToRegAlu  = 2'b00;
  localparam logic [1:0] MemToRegMdr  = 2'b01;
  localparam logic [1:0] MemToRegLink = 2'b10;

  localparam logic [2:0] F3Beq = 3'b000;
  localparam logic [2:0] F3Bne = 3'b001;
  localparam logic [2:0] F3Blt = 3'b100;
  localparam logic [2:0] F3Bge = 3'b101;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecR,
    StWbR,
    StAddr,
    StMemRd,
    StWbLd,
    StMemWr,
    StBrCmp,
    StJal,
    StIllegal
  } state_e;

  // State following DECODE for a given opcode.
  function automatic state_e decode_next(logic [6:0] op);
    state_e nxt;
    case (op)
      OpRtype:         nxt = StExecR;
      OpLoad, OpStore: nxt = StAddr;
      OpBranch:        nxt = StBrCmp;
      OpJal:           nxt = StJal;
      default:         nxt = StIllegal;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_main_control_branch_resolve.sv
// Branch resolution from ALU flags.
// Ports: fun3 (branch kind), alu_zero / alu_sign / alu_lsb (ALU flags) -> taken.
// BLT relies on the ALU running SLT for aluop=01, so its result lsb is the outcome.
module multicycle_main_control_branch_resolve
  import multicycle_main_control_pkg::*;
(
  input  logic [2:0] fun3,
  input  logic       alu_zero,
  input  logic       alu_sign,
  input  logic       alu_lsb,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (fun3)
      F3Beq:   taken = alu_zero;
      F3Bne:   taken = ~alu_zero;
      F3Blt:   taken = alu_lsb;
      F3Bge:   taken = ~alu_sign;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle RV32 datapath.
// Inputs : clk, reset_n (sync, active-low), opcode, fun3, mem_ready, alu_zero/sign/lsb.
// Outputs: aluop, alusrc_a, alusrc_b, iord, mem_read, mem_write, ir_write, pc_write, pc_src,
//          reg_write, mem_to_reg, illegal_instr, mem_timeout.
// Outputs are a Moore decode of the state; pc_write in BR_CMP follows the branch result and
// memory states react to mem_ready / the wait-counter limit.
module multicycle_main_control
  import multicycle_main_control_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic [2:0] fun3,
  input  logic       mem_ready,
  input  logic       alu_zero,
  input  logic       alu_sign,
  input  logic       alu_lsb,
  output logic [1:0] aluop,
  output logic [1:0] alusrc_a,
  output logic [1:0] alusrc_b,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       illegal_instr,
  output logic       mem_timeout
);

  state_e             state_q, state_d;
  logic   [CNT_W-1:0] cnt_q, cnt_d;
  logic               taken;
  logic               timeout_hit;

  multicycle_main_control_branch_resolve u_branch_resolve (
    .fun3     (fun3),
    .alu_zero (alu_zero),
    .alu_sign (alu_sign),
    .alu_lsb  (alu_lsb),
    .taken    (taken)
  );

  // mem_ready in the limit cycle counts as a normal completion.
  assign timeout_hit = (WAIT_LIMIT != 0) && (cnt_q == CNT_W'(WAIT_LIMIT)) && !mem_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;  // leaving a wait state always clears the counter
    aluop         = AluopAdd;
    alusrc_a      = SrcAPc;
    alusrc_b      = SrcBRs2;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = MemToRegAlu;
    illegal_instr = 1'b0;
    mem_timeout   = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        alusrc_b = SrcBFour;
        if (timeout_hit) begin
          mem_timeout = 1'b1;
          state_d     = StFetch;
        end else begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = StDecode;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDecode: begin
        alusrc_a = SrcAOldPc;
        alusrc_b = SrcBImm;
        state_d  = decode_next(opcode);
      end
      StExecR: begin
        alusrc_a = SrcARs1;
        alusrc_b = SrcBRs2;
        aluop    = AluopR;
        state_d  = StWbR;
      end
      StWbR: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StAddr: begin
        alusrc_a = SrcARs1;
        alusrc_b = SrcBImm;
        state_d  = (opcode == OpStore) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        if (timeout_hit) begin
          mem_timeout = 1'b1;
          state_d     = StFetch;
        end else begin
          iord     = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) state_d = StWbLd;
          else           cnt_d   = cnt_q + 1'b1;
        end
      end
      StWbLd: begin
        reg_write  = 1'b1;
        mem_to_reg = MemToRegMdr;
        state_d    = StFetch;
      end
      StMemWr: begin
        if (timeout_hit) begin
          mem_timeout = 1'b1;
          state_d     = StFetch;
        end else begin
          iord      = 1'b1;
          mem_write = 1'b1;
          if (mem_ready) state_d = StFetch;
          else           cnt_d   = cnt_q + 1'b1;
        end
      end
      StBrCmp: begin
        alusrc_a = SrcARs1;
        alusrc_b = SrcBRs2;
        aluop    = AluopBr;
        pc_src   = 1'b1;
        pc_write = taken;
        state_d  = StFetch;
      end
      StJal: begin
        pc_write   = 1'b1;
        pc_src     = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = MemToRegLink;
        state_d    = StFetch;
      end
      StIllegal: begin
        illegal_instr = 1'b1;
        state_d       = StFetch;
      end
      default: state_d = StIdle;
    endcase

    // An instruction interrupted by reset must not commit anything in the reset cycle.
    if (!reset_n) begin
      aluop         = AluopAdd;
      alusrc_a      = SrcAPc;
      alusrc_b      = SrcBRs2;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_src        = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = MemToRegAlu;
      illegal_instr = 1'b0;
      mem_timeout   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: walks instruction classes through the FSM and
// compares the full output vector each cycle against hand-written expectations.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] opcode;
  logic [2:0] fun3;
  logic       mem_ready;
  logic       alu_zero, alu_sign, alu_lsb;
  logic [1:0] aluop, alusrc_a, alusrc_b, mem_to_reg;
  logic       iord, mem_read, mem_write, ir_write, pc_write, pc_src, reg_write;
  logic       illegal_instr, mem_timeout;

  int total = 0;
  int bad   = 0;

  multicycle_main_control #(
    .WAIT_LIMIT (16),
    .CNT_W      (5)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .fun3          (fun3),
    .mem_ready     (mem_ready),
    .alu_zero      (alu_zero),
    .alu_sign      (alu_sign),
    .alu_lsb       (alu_lsb),
    .aluop         (aluop),
    .alusrc_a      (alusrc_a),
    .alusrc_b      (alusrc_b),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .illegal_instr (illegal_instr),
    .mem_timeout   (mem_timeout)
  );

  always #5 clk = ~clk;

  // Expected output vector built from individual hand-chosen field values.
  function automatic logic [16:0] ov(logic [1:0] op, logic [1:0] sa, logic [1:0] sb, logic io,
                                     logic mr, logic mw, logic ir, logic pw, logic ps, logic rw,
                                     logic [1:0] m2r, logic ill, logic to);
    return {op, sa, sb, io, mr, mw, ir, pw, ps, rw, m2r, ill, to};
  endfunction

  logic [16:0] obs;
  assign obs = {aluop, alusrc_a, alusrc_b, iord, mem_read, mem_write, ir_write, pc_write,
                pc_src, reg_write, mem_to_reg, illegal_instr, mem_timeout};

  localparam logic [16:0] VZero    = 17'h0;
  // Field order: aluop sa sb iord mr mw ir pw ps rw m2r ill to
  logic [16:0] v_fetch_wait, v_fetch_rdy, v_decode, v_exec_r, v_wb_r, v_addr, v_mem_rd;
  logic [16:0] v_wb_ld, v_mem_wr, v_br_t, v_br_n, v_jal, v_ill, v_fetch_to;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [16:0] exp);
    #1;
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // FETCH with zero-wait memory followed by DECODE.
  task automatic fetch_decode(input logic [6:0] op);
    opcode    = op;
    mem_ready = 1'b1;
    chk("fetch_rdy", v_fetch_rdy);
    cyc();
    mem_ready = 1'b0;
    chk("decode", v_decode);
    cyc();
  endtask

  logic [2:0] br_f3  [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b101, 3'b010};
  logic       br_z   [6] = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b1,   1'b1};
  logic       br_s   [6] = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b0,   1'b0};
  logic       br_l   [6] = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1};
  logic       br_tk  [6] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0};

  initial begin
    v_fetch_wait = ov(2'b00, 2'b00, 2'b01, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    v_fetch_rdy  = ov(2'b00, 2'b00, 2'b01, 0, 1, 0, 1, 1, 0, 0, 2'b00, 0, 0);
    v_decode     = ov(2'b00, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    v_exec_r     = ov(2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    v_wb_r       = ov(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
    v_addr       = ov(2'b00, 2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    v_mem_rd     = ov(2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    v_wb_ld      = ov(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 0);
    v_mem_wr     = ov(2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0);
    v_br_t       = ov(2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 0);
    v_br_n       = ov(2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0);
    v_jal        = ov(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 1, 2'b10, 0, 0);
    v_ill        = ov(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    v_fetch_to   = ov(2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);

    reset_n   = 1'b0;
    opcode    = 7'b0110011;
    fun3      = 3'b000;
    mem_ready = 1'b0;
    alu_zero  = 1'b0;
    alu_sign  = 1'b0;
    alu_lsb   = 1'b0;

    // Reset, then IDLE, then FETCH.
    cyc();
    cyc();
    chk("reset", VZero);
    reset_n = 1'b1;
    chk("idle", VZero);
    cyc();
    chk("first_fetch", v_fetch_wait);

    // R-type with zero-wait memory: reg_write in the 4th cycle.
    fetch_decode(7'b0110011);
    chk("exec_r", v_exec_r);
    cyc();
    chk("wb_r", v_wb_r);
    cyc();
    chk("r_back_fetch", v_fetch_wait);

    // LW with mem_ready held off for 3 MEM_RD cycles.
    fetch_decode(7'b0000011);
    chk("lw_addr", v_addr);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("lw_mem_wait", v_mem_rd);
      cyc();
    end
    mem_ready = 1'b1;
    chk("lw_mem_rdy", v_mem_rd);
    cyc();
    mem_ready = 1'b0;
    chk("lw_wb", v_wb_ld);
    cyc();
    chk("lw_back_fetch", v_fetch_wait);

    // Branches: BEQ z, BNE z, BLT lsb, BGE sign, BGE !sign, unsupported fun3.
    for (int b = 0; b < 6; b++) begin
      fun3     = br_f3[b];
      alu_zero = br_z[b];
      alu_sign = br_s[b];
      alu_lsb  = br_l[b];
      fetch_decode(7'b1100011);
      chk($sformatf("br%0d_cmp", b), br_tk[b] ? v_br_t : v_br_n);
      cyc();
      chk($sformatf("br%0d_fetch", b), v_fetch_wait);
    end
    alu_zero = 1'b0;
    alu_sign = 1'b0;
    alu_lsb  = 1'b0;

    // JAL.
    fetch_decode(7'b1101111);
    chk("jal", v_jal);
    cyc();
    chk("jal_back_fetch", v_fetch_wait);

    // Unsupported opcode.
    fetch_decode(7'b0010111);
    chk("illegal", v_ill);
    cyc();
    chk("illegal_back_fetch", v_fetch_wait);

    // SW: store completes with zero wait.
    fetch_decode(7'b0100011);
    chk("sw_addr", v_addr);
    cyc();
    mem_ready = 1'b1;
    chk("sw_mem_rdy", v_mem_wr);
    cyc();
    mem_ready = 1'b0;
    chk("sw_back_fetch", v_fetch_wait);

    // SW aborted by reset in MEM_WR.
    fetch_decode(7'b0100011);
    chk("sw2_addr", v_addr);
    cyc();
    chk("sw2_mem_wait", v_mem_wr);
    reset_n = 1'b0;
    chk("sw2_reset_cycle", VZero);
    cyc();
    chk("sw2_after_reset", VZero);
    reset_n = 1'b1;
    chk("sw2_idle", VZero);
    cyc();
    chk("sw2_fetch", v_fetch_wait);

    // FETCH timeout: 16 waiting cycles, 17th pulses mem_timeout.
    for (int i = 1; i < 16; i++) begin
      cyc();
      chk($sformatf("to_wait%0d", i), v_fetch_wait);
    end
    cyc();
    chk("to_limit", v_fetch_to);
    cyc();
    chk("to_restart", v_fetch_wait);

    // Counter restarted; mem_ready arriving exactly at the limit completes normally.
    for (int i = 1; i < 16; i++) begin
      cyc();
      chk($sformatf("lim_wait%0d", i), v_fetch_wait);
    end
    cyc();
    opcode    = 7'b0110011;
    mem_ready = 1'b1;
    chk("lim_ready_wins", v_fetch_rdy);
    cyc();
    mem_ready = 1'b0;
    chk("lim_decode", v_decode);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
